// File: rtl/gray_count_checker_pkg.sv
// rtl/gray_count_checker_pkg.sv - shared types and defaults for the Gray count checker
// Contents: state_t (checker FSM encoding) and default values for WIDTH,
// LOCK_CNT and ERR_CNT_W used by the interface and the top level.
package gray_chk_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_LOST    = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_LOCK_CNT  = 4;
  localparam int DEF_ERR_CNT_W = 8;

endpackage

// File: rtl/gray_count_checker_if.sv
// rtl/gray_count_checker_if.sv - signal bundle between Gray counter, checker and observers
// Signals:
//   i_gray_cnt  Gray count from the upstream counter
//   o_bin_cnt   binary decode of the previous sample
//   o_locked    checker is in LOCKED
//   o_err       one-cycle pulse on a bad step while locked
//   o_wrap      one-cycle pulse on an all-ones -> 0 step while locked
//   o_err_cnt   saturating count of o_err pulses
//   o_state     checker FSM state
// Modports: master = checker side, slave = driver/observer side.
interface gray_count_checker_if
  import gray_chk_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) ();

  logic [WIDTH-1:0]     i_gray_cnt;
  logic [WIDTH-1:0]     o_bin_cnt;
  logic                 o_locked;
  logic                 o_err;
  logic                 o_wrap;
  logic [ERR_CNT_W-1:0] o_err_cnt;
  state_t               o_state;

  modport master (
    input  i_gray_cnt,
    output o_bin_cnt, o_locked, o_err, o_wrap, o_err_cnt, o_state
  );

  modport slave (
    output i_gray_cnt,
    input  o_bin_cnt, o_locked, o_err, o_wrap, o_err_cnt, o_state
  );

endinterface

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray-to-binary decoder
// Ports:
//   i_gray  WIDTH-bit Gray code in
//   o_bin   WIDTH-bit binary out; o_bin[i] = XOR of i_gray[WIDTH-1:i]
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Shifting right by i leaves exactly gray[WIDTH-1:i] to reduce.
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/gray_count_checker.sv
// rtl/gray_count_checker.sv - monitors a Gray counter for +1 steps, lock, wrap and errors
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    gray_count_checker_if.master (i_gray_cnt in; o_bin_cnt, o_locked,
//          o_err, o_wrap, o_err_cnt, o_state out; all outputs registered)
module gray_count_checker
  import gray_chk_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LOCK_CNT  = DEF_LOCK_CNT,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_count_checker_if.master bus
);

  localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
  localparam logic [3:0]           LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  logic [WIDTH-1:0]     w_bin;
  logic [WIDTH-1:0]     w_bin_inc;
  logic                 w_good;
  logic                 w_stall;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_bin_q;
  logic                 r_prev_valid;
  logic [3:0]           r_run;
  logic [3:0]           w_run_nxt;
  logic                 r_err;
  logic                 w_err_nxt;
  logic                 r_wrap;
  logic                 w_wrap_nxt;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [ERR_CNT_W-1:0] w_err_cnt_nxt;

  gray_to_bin #(.WIDTH(WIDTH)) u_dec (
    .i_gray (bus.i_gray_cnt),
    .o_bin  (w_bin)
  );

  // Increment wraps naturally at WIDTH bits, giving the mod 2^WIDTH step.
  assign w_bin_inc = r_bin_q + ONE;
  assign w_good    = r_prev_valid && (w_bin == w_bin_inc);
  assign w_stall   = r_prev_valid && (w_bin == r_bin_q);

  always_comb begin
    w_state_nxt   = r_state;
    w_run_nxt     = r_run;
    w_err_nxt     = 1'b0;
    w_wrap_nxt    = 1'b0;
    w_err_cnt_nxt = r_err_cnt;
    // The first sample after reset only primes r_bin_q.
    if (r_prev_valid) begin
      case (r_state)
        ST_ACQUIRE: begin
          if (w_good) begin
            if (r_run + 4'd1 == LOCK_TGT) begin
              w_state_nxt = ST_LOCKED;
              w_run_nxt   = 4'd0;
            end else begin
              w_run_nxt = r_run + 4'd1;
            end
          end else if (!w_stall) begin
            w_run_nxt = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (w_good) begin
            w_wrap_nxt = &r_bin_q;
          end else if (!w_stall) begin
            w_err_nxt     = 1'b1;
            w_err_cnt_nxt = (r_err_cnt == ERR_MAX) ? r_err_cnt : r_err_cnt + 1'b1;
            w_state_nxt   = ST_LOST;
          end
        end
        ST_LOST: begin
          if (w_good) begin
            // The recovering step already counts as the first good step.
            if (LOCK_TGT == 4'd1) begin
              w_state_nxt = ST_LOCKED;
              w_run_nxt   = 4'd0;
            end else begin
              w_state_nxt = ST_ACQUIRE;
              w_run_nxt   = 4'd1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_ACQUIRE;
          w_run_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_ACQUIRE;
      r_bin_q      <= '0;
      r_prev_valid <= 1'b0;
      r_run        <= 4'd0;
      r_err        <= 1'b0;
      r_wrap       <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_bin_q      <= w_bin;
      r_prev_valid <= 1'b1;
      r_run        <= w_run_nxt;
      r_err        <= w_err_nxt;
      r_wrap       <= w_wrap_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
    end
  end

  assign bus.o_bin_cnt = r_bin_q;
  assign bus.o_locked  = (r_state == ST_LOCKED);
  assign bus.o_err     = r_err;
  assign bus.o_wrap    = r_wrap;
  assign bus.o_err_cnt = r_err_cnt;
  assign bus.o_state   = r_state;

endmodule

// File: tb/tb_gray_count_checker.sv
// tb/tb_gray_count_checker.sv - directed self-checking bench for gray_count_checker
module tb_gray_count_checker;
  import gray_chk_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  gray_count_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();

  gray_count_checker #(.WIDTH(4), .LOCK_CNT(4), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [3:0] g_of(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic step(input logic [3:0] g);
    bus.i_gray_cnt = g;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) step(4'b0000);
    n_total++;
    if (bus.o_bin_cnt !== 4'd0) $display("FAIL reset_bin: got %0d expected 0", bus.o_bin_cnt);
    else n_pass++;
    n_total++;
    if ({bus.o_locked, bus.o_err, bus.o_wrap} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {bus.o_locked, bus.o_err, bus.o_wrap});
    else n_pass++;
    n_total++;
    if (bus.o_err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d expected 0", bus.o_err_cnt);
    else n_pass++;
    n_total++;
    if (bus.o_state !== ST_ACQUIRE) $display("FAIL reset_state: got %0d expected 0", bus.o_state);
    else n_pass++;
  endtask

  task automatic test_lock;
    logic [3:0] gv[5];
    logic [3:0] eb[5];
    logic       el[5];
    gv = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    eb = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(gv[i]);
      n_total++;
      if (bus.o_bin_cnt !== eb[i] || bus.o_locked !== el[i] || bus.o_err !== 1'b0)
        $display("FAIL lock_step%0d: got bin=%0d locked=%b err=%b expected bin=%0d locked=%b err=0",
                 i, bus.o_bin_cnt, bus.o_locked, bus.o_err, eb[i], el[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap;
    int wraps = 0;
    int miss = 0;
    for (int i = 0; i < 48; i++) begin
      step(g_of(5 + i));
      if (bus.o_wrap === 1'b1) wraps++;
      if (bus.o_bin_cnt !== 4'(5 + i) || bus.o_wrap !== (((5 + i) % 16) == 0) || bus.o_err !== 1'b0)
        miss++;
    end
    n_total++;
    if (wraps !== 3) $display("FAIL wrap_count: got %0d expected 3", wraps);
    else n_pass++;
    n_total++;
    if (miss !== 0) $display("FAIL wrap_sequence: got %0d bad cycles expected 0", miss);
    else n_pass++;
    n_total++;
    if (bus.o_err_cnt !== 8'd0 || bus.o_locked !== 1'b1)
      $display("FAIL wrap_end: got err_cnt=%0d locked=%b expected 0 1", bus.o_err_cnt, bus.o_locked);
    else n_pass++;
  endtask

  task automatic test_skip_relock;
    for (int b = 5; b <= 17; b++) step(g_of(b));
    step(4'b0011);
    n_total++;
    if (bus.o_err !== 1'b0 || bus.o_locked !== 1'b1)
      $display("FAIL skip_pre: got err=%b locked=%b expected 0 1", bus.o_err, bus.o_locked);
    else n_pass++;
    step(4'b0110);
    n_total++;
    if (bus.o_err !== 1'b1 || bus.o_err_cnt !== 8'd1 || bus.o_locked !== 1'b0 ||
        bus.o_state !== ST_LOST || bus.o_wrap !== 1'b0)
      $display("FAIL skip_err: got err=%b cnt=%0d locked=%b state=%0d wrap=%b expected 1 1 0 2 0",
               bus.o_err, bus.o_err_cnt, bus.o_locked, bus.o_state, bus.o_wrap);
    else n_pass++;
    step(4'b0111);
    n_total++;
    if (bus.o_state !== ST_ACQUIRE || bus.o_err !== 1'b0 || bus.o_err_cnt !== 8'd1)
      $display("FAIL relock_acq: got state=%0d err=%b cnt=%0d expected 0 0 1",
               bus.o_state, bus.o_err, bus.o_err_cnt);
    else n_pass++;
    step(4'b0101);
    step(4'b0100);
    n_total++;
    if (bus.o_locked !== 1'b0) $display("FAIL relock_early: got locked=%b expected 0", bus.o_locked);
    else n_pass++;
    step(4'b1100);
    n_total++;
    if (bus.o_locked !== 1'b1 || bus.o_state !== ST_LOCKED)
      $display("FAIL relock_done: got locked=%b state=%0d expected 1 1", bus.o_locked, bus.o_state);
    else n_pass++;
  endtask

  task automatic test_stall;
    for (int b = 9; b <= 20; b++) step(g_of(b));
    for (int i = 0; i < 3; i++) begin
      step(4'b0110);
      n_total++;
      if (bus.o_err !== 1'b0 || bus.o_locked !== 1'b1 || bus.o_bin_cnt !== 4'd4)
        $display("FAIL stall_locked%0d: got err=%b locked=%b bin=%0d expected 0 1 4",
                 i, bus.o_err, bus.o_locked, bus.o_bin_cnt);
      else n_pass++;
    end
    step(g_of(9));
    n_total++;
    if (bus.o_err !== 1'b1 || bus.o_err_cnt !== 8'd2)
      $display("FAIL stall_err: got err=%b cnt=%0d expected 1 2", bus.o_err, bus.o_err_cnt);
    else n_pass++;
    step(g_of(10));
    step(g_of(11));
    step(g_of(11));
    n_total++;
    if (bus.o_state !== ST_ACQUIRE || bus.o_err !== 1'b0)
      $display("FAIL stall_acq: got state=%0d err=%b expected 0 0", bus.o_state, bus.o_err);
    else n_pass++;
    step(g_of(12));
    n_total++;
    if (bus.o_locked !== 1'b0) $display("FAIL stall_run_early: got locked=%b expected 0", bus.o_locked);
    else n_pass++;
    step(g_of(13));
    n_total++;
    if (bus.o_locked !== 1'b1) $display("FAIL stall_run_lock: got locked=%b expected 1", bus.o_locked);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    step(g_of(0));
    for (int b = 1; b <= 4; b++) step(g_of(b));
    n_total++;
    if (bus.o_locked !== 1'b1 || bus.o_err_cnt !== 8'd3)
      $display("FAIL midrst_pre: got locked=%b cnt=%0d expected 1 3", bus.o_locked, bus.o_err_cnt);
    else n_pass++;
    rst_n = 1'b0;
    step(g_of(5));
    n_total++;
    if (bus.o_bin_cnt !== 4'd0 || bus.o_locked !== 1'b0 || bus.o_err !== 1'b0 ||
        bus.o_wrap !== 1'b0 || bus.o_err_cnt !== 8'd0 || bus.o_state !== ST_ACQUIRE)
      $display("FAIL midrst_outputs: got bin=%0d locked=%b err=%b wrap=%b cnt=%0d state=%0d expected all 0",
               bus.o_bin_cnt, bus.o_locked, bus.o_err, bus.o_wrap, bus.o_err_cnt, bus.o_state);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_saturation;
    int b = 0;
    int bad_lock = 0;
    int bad_err = 0;
    int bad_cnt = 0;
    int exp_cnt;
    step(g_of(b));
    for (int k = 1; k <= 300; k++) begin
      for (int j = 0; j < 4; j++) begin
        b++;
        step(g_of(b));
      end
      if (bus.o_locked !== 1'b1) bad_lock++;
      b += 3;
      step(g_of(b));
      exp_cnt = (k > 255) ? 255 : k;
      if (bus.o_err !== 1'b1) bad_err++;
      if (bus.o_err_cnt !== 8'(exp_cnt)) bad_cnt++;
    end
    n_total++;
    if (bad_lock !== 0) $display("FAIL sat_lock: got %0d unlocked rounds expected 0", bad_lock);
    else n_pass++;
    n_total++;
    if (bad_err !== 0) $display("FAIL sat_err_pulse: got %0d missing pulses expected 0", bad_err);
    else n_pass++;
    n_total++;
    if (bad_cnt !== 0) $display("FAIL sat_cnt_track: got %0d wrong counts expected 0", bad_cnt);
    else n_pass++;
    n_total++;
    if (bus.o_err_cnt !== 8'd255) $display("FAIL sat_final: got %0d expected 255", bus.o_err_cnt);
    else n_pass++;
  endtask

  initial begin
    bus.i_gray_cnt = 4'b0000;
    test_reset();
    test_lock();
    test_wrap();
    test_skip_relock();
    test_stall();
    test_mid_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
